// File: rtl/eth_rx_parser_pkg.sv
// Shared types and constants for the Ethernet receive parser.
package eth_pkg;

   localparam int ETH_ADDR_W = 32;

   localparam logic [ETH_ADDR_W-1:0] ETH_PORT_A_ADDR = 32'hABCD;
   localparam logic [ETH_ADDR_W-1:0] ETH_PORT_B_ADDR = 32'hEFEF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } rx_state_e;

endpackage

// File: rtl/eth_rx_parser_if.sv
// Ingress/egress bus of the receive parser. The parser is the slave; the
// surrounding source/FIFO environment is the master.
interface eth_rx_parser_if #(
   parameter int DATA_W = 32,
   parameter int PORT_W = 1
);
   logic              in_valid;
   logic              in_ready;
   logic              insop;
   logic              ineop;
   logic [DATA_W-1:0] indata;
   logic              out_full;
   logic              out_wr_en;
   logic [DATA_W-1:0] out_data;
   logic              out_sop;
   logic              out_eop;
   logic              out_err;
   logic [PORT_W-1:0] out_port;

   modport slave (
      input  in_valid, insop, ineop, indata, out_full,
      output in_ready, out_wr_en, out_data, out_sop, out_eop, out_err, out_port
   );

   modport master (
      output in_valid, insop, ineop, indata, out_full,
      input  in_ready, out_wr_en, out_data, out_sop, out_eop, out_err, out_port
   );
endinterface

// File: rtl/eth_rx_parser_sat_counter.sv
// Saturating up-counter used for the parser statistics.
module eth_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] count
);
   logic [W-1:0] count_r;

   // Count increments, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
endmodule

// File: rtl/eth_rx_parser.sv
// Framed receive parser: matches the header address against a port table,
// forwards matching packets tagged with their port, and drops, truncates or
// aborts malformed ones while keeping saturating statistics.
module eth_rx_parser
   import eth_pkg::*;
#(
   parameter int                             DATA_W     = 32,
   parameter int                             NUM_PORTS  = 2,
   parameter logic [NUM_PORTS*ETH_ADDR_W-1:0] PORT_ADDRS = {ETH_PORT_B_ADDR, ETH_PORT_A_ADDR},
   parameter int                             MAX_WORDS  = 16,
   parameter int                             CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rstn,
   eth_rx_parser_if.slave   bus,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int WC_W   = $clog2(MAX_WORDS + 1);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(MAX_WORDS - 1);
   localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);

   rx_state_e          state_r;
   logic [WC_W-1:0]    word_cnt_r;
   logic               out_wr_en_r;
   logic [DATA_W-1:0]  out_data_r;
   logic               out_sop_r;
   logic               out_eop_r;
   logic               out_err_r;
   logic [PORT_W-1:0]  out_port_r;

   logic               accept_s;
   logic               hit_s;
   logic [PORT_W-1:0]  hit_idx_s;
   logic               pkt_inc_s;
   logic               drop_inc_s;

   assign bus.in_ready = !bus.out_full;
   assign accept_s     = bus.in_valid && !bus.out_full;

   // Priority address match: the first (lowest) matching table entry wins.
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = {PORT_W{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!hit_s && (bus.indata[ETH_ADDR_W-1:0] == PORT_ADDRS[i*ETH_ADDR_W +: ETH_ADDR_W])) begin
            hit_s     = 1'b1;
            hit_idx_s = PORT_W'(i);
         end else begin
            hit_s     = hit_s;
         end
      end
   end

   // Statistics strobes; a beat bumps at most one of the two counters.
   always_comb begin
      pkt_inc_s  = 1'b0;
      drop_inc_s = 1'b0;
      if (accept_s) begin
         case (state_r)
            IDLE: begin
               drop_inc_s = bus.insop && (!hit_s || bus.ineop);
            end
            PAYLOAD: begin
               if (bus.insop) begin
                  drop_inc_s = 1'b1;
               end else if (bus.ineop) begin
                  pkt_inc_s = 1'b1;
               end else if (word_cnt_r == LAST_WORD) begin
                  drop_inc_s = 1'b1;
               end else begin
                  drop_inc_s = 1'b0;
               end
            end
            default: begin
               drop_inc_s = 1'b0;
            end
         endcase
      end else begin
         pkt_inc_s  = 1'b0;
         drop_inc_s = 1'b0;
      end
   end

   // Packet FSM with registered egress; stalls hold state and word count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= IDLE;
         word_cnt_r  <= {WC_W{1'b0}};
         out_wr_en_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_sop_r   <= 1'b0;
         out_eop_r   <= 1'b0;
         out_err_r   <= 1'b0;
         out_port_r  <= {PORT_W{1'b0}};
      end else begin
         out_wr_en_r <= 1'b0;
         out_sop_r   <= 1'b0;
         out_eop_r   <= 1'b0;
         out_err_r   <= 1'b0;
         if (accept_s) begin
            case (state_r)
               IDLE: begin
                  if (bus.insop && hit_s && !bus.ineop) begin
                     out_wr_en_r <= 1'b1;
                     out_data_r  <= bus.indata;
                     out_sop_r   <= 1'b1;
                     out_port_r  <= hit_idx_s;
                     word_cnt_r  <= {WC_W{1'b0}};
                     state_r     <= PAYLOAD;
                  end else if (bus.insop && !hit_s && !bus.ineop) begin
                     state_r <= DROP;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               PAYLOAD: begin
                  out_wr_en_r <= 1'b1;
                  if (bus.insop) begin
                     // Aborted packet: close it with an errored zero word.
                     out_data_r <= {DATA_W{1'b0}};
                     out_eop_r  <= 1'b1;
                     out_err_r  <= 1'b1;
                     state_r    <= bus.ineop ? IDLE : DROP;
                  end else if (bus.ineop) begin
                     out_data_r <= bus.indata;
                     out_eop_r  <= 1'b1;
                     state_r    <= IDLE;
                  end else if (word_cnt_r == LAST_WORD) begin
                     // Overlength: truncate here and discard the tail.
                     out_data_r <= bus.indata;
                     out_eop_r  <= 1'b1;
                     out_err_r  <= 1'b1;
                     state_r    <= DROP;
                  end else begin
                     out_data_r <= bus.indata;
                     word_cnt_r <= word_cnt_r + WC_ONE;
                  end
               end
               DROP: begin
                  state_r <= bus.ineop ? IDLE : DROP;
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign bus.out_wr_en = out_wr_en_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_sop   = out_sop_r;
   assign bus.out_eop   = out_eop_r;
   assign bus.out_err   = out_err_r;
   assign bus.out_port  = out_port_r;

   eth_sat_counter #(.W(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (pkt_inc_s),
      .count (pkt_cnt)
   );

   eth_sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (drop_inc_s),
      .count (drop_cnt)
   );
endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser with MAX_WORDS=4 and CNT_W=2.
module tb_eth_rx_parser;
   import eth_pkg::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 2;

   logic             clk;
   logic             rstn;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] drop_cnt;

   int n_checks;
   int n_fail;

   logic [63:0] exp_q[$];

   eth_rx_parser_if #(.DATA_W(DATA_W), .PORT_W(1)) bus ();

   eth_rx_parser #(
      .DATA_W    (DATA_W),
      .NUM_PORTS (2),
      .PORT_ADDRS({32'hEFEF, 32'hABCD}),
      .MAX_WORDS (4),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus.slave),
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic sop, input logic eop, input logic err,
                                      input logic port, input logic [31:0] data);
      return {28'd0, sop, eop, err, port, data};
   endfunction

   // Every emitted word must match the next expected word, in order.
   always @(negedge clk) begin
      if (bus.out_wr_en) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_wr", {63'd0, bus.out_wr_en}, 64'd0);
         end else begin
            check_eq("out_word",
                     mk(bus.out_sop, bus.out_eop, bus.out_err, bus.out_port, bus.out_data),
                     exp_q.pop_front());
         end
      end
   end

   task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
      bus.in_valid = v;
      bus.insop    = s;
      bus.ineop    = e;
      bus.indata   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic check_done(input string tag, input int exp_pkt, input int exp_drop);
      check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      check_eq({tag, "_pkt_cnt"}, {62'd0, pkt_cnt}, 64'(exp_pkt));
      check_eq({tag, "_drop_cnt"}, {62'd0, drop_cnt}, 64'(exp_drop));
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      bus.in_valid = 1'b0;
      bus.insop    = 1'b0;
      bus.ineop    = 1'b0;
      bus.indata   = 32'd0;
      bus.out_full = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      check_eq("rst_outputs",
               mk(bus.out_sop, bus.out_eop, bus.out_err, bus.out_port, bus.out_data)
               | {27'd0, bus.out_wr_en, 36'd0}, 64'd0);
      check_eq("rst_counters", {60'd0, pkt_cnt, drop_cnt}, 64'd0);
      check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Good packet to port 1.
      do_reset();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hEFEF));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd1));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd2));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd3));
      drive(1'b1, 1'b1, 1'b0, 32'hEFEF);
      drive(1'b1, 1'b0, 1'b0, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'd2);
      drive(1'b1, 1'b0, 1'b1, 32'd3);
      idle(2);
      check_done("good", 1, 0);

      // Stray beat, unknown address, then a good packet to port 0.
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'd99);
      idle(1);
      check_done("stray", 0, 0);
      drive(1'b1, 1'b1, 1'b0, 32'h1234);
      drive(1'b1, 1'b0, 1'b0, 32'd5);
      drive(1'b1, 1'b0, 1'b1, 32'd6);
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd7));
      drive(1'b1, 1'b1, 1'b0, 32'hABCD);
      drive(1'b1, 1'b0, 1'b1, 32'd7);
      idle(2);
      check_done("badaddr", 1, 1);

      // Overlength: header plus 6 words, truncated after the 4th.
      do_reset();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd11));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd12));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd13));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'd14));
      drive(1'b1, 1'b1, 1'b0, 32'hABCD);
      for (int k = 11; k <= 16; k++) drive(1'b1, 1'b0, (k == 16), 32'(k));
      idle(2);
      check_done("overlen", 0, 1);

      // Missing eop, then a runt header.
      do_reset();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hEFEF));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd21));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd22));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'd0));
      drive(1'b1, 1'b1, 1'b0, 32'hEFEF);
      drive(1'b1, 1'b0, 1'b0, 32'd21);
      drive(1'b1, 1'b0, 1'b0, 32'd22);
      drive(1'b1, 1'b1, 1'b0, 32'hABCD);
      drive(1'b1, 1'b0, 1'b0, 32'd31);
      drive(1'b1, 1'b0, 1'b1, 32'd32);
      idle(2);
      check_done("noeop", 0, 1);
      drive(1'b1, 1'b1, 1'b1, 32'hABCD);
      idle(2);
      check_done("runt", 0, 2);

      // Backpressure mid-packet with in_valid held high.
      do_reset();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd41));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'd42));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'd43));
      drive(1'b1, 1'b1, 1'b0, 32'hABCD);
      drive(1'b1, 1'b0, 1'b0, 32'd41);
      bus.out_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.insop    = 1'b0;
         bus.ineop    = 1'b0;
         bus.indata   = 32'd42;
         #1;
         check_eq("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
         @(posedge clk);
         #1;
      end
      bus.out_full = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 32'd42);
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      drive(1'b1, 1'b0, 1'b1, 32'd43);
      idle(2);
      check_done("bp", 1, 0);

      // Asynchronous reset while in PAYLOAD, between clock edges.
      do_reset();
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hEFEF));
      drive(1'b1, 1'b1, 1'b0, 32'hEFEF);
      drive(1'b1, 1'b0, 1'b0, 32'd51);
      bus.in_valid = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      check_eq("arst_outputs",
               mk(bus.out_sop, bus.out_eop, bus.out_err, bus.out_port, bus.out_data)
               | {27'd0, bus.out_wr_en, 36'd0}, 64'd0);
      check_eq("arst_counters", {60'd0, pkt_cnt, drop_cnt}, 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      // Back in IDLE, a payload-looking beat must be discarded.
      drive(1'b1, 1'b0, 1'b1, 32'd52);
      idle(2);
      check_done("arst", 0, 0);

      // Drop counter saturation with CNT_W=2.
      do_reset();
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b1, 32'h1234);
      idle(1);
      check_eq("sat_at3", {62'd0, drop_cnt}, 64'd3);
      for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 1'b1, 32'h1234);
      idle(2);
      check_done("sat", 0, 3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
